// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin grant arbiter for 4 requesters with hold timeout
// Grant is held until done/request drop or the hold timer expires; one idle cycle follows every release.

module decoder_2_to_4 (
    input  logic [1:0] sel,
    input  logic       ena,
    output logic [3:0] dout
);

    always_comb begin
        dout = 4'b0000;
        if (ena) begin
            dout[sel] = 1'b1;
        end
    end

endmodule

module rr_grant_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic       HOLD_EN    = (MAX_HOLD != 0);

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hold_cnt;

    logic       search_hit;
    logic [1:0] search_idx;
    logic [1:0] cand;

    logic       rel_done;
    logic       rel_req;
    logic       rel_to;

    // Rotating priority search: ptr has the highest priority, ptr-1 the lowest.
    always_comb begin
        search_hit = 1'b0;
        search_idx = ptr;
        cand       = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!search_hit && req[cand]) begin
                search_hit = 1'b1;
                search_idx = cand;
            end
        end
    end

    always_comb begin
        rel_done = done[grant_idx];
        rel_req  = !req[grant_idx];
        rel_to   = HOLD_EN && (hold_cnt == HOLD_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            hold_cnt    <= 8'd0;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (search_hit) begin
                        state       <= GRANT;
                        grant_idx   <= search_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= 8'd1;
                        ptr         <= search_idx + 2'd1;
                    end
                end
                GRANT: begin
                    if (rel_done || rel_req || rel_to) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        hold_cnt    <= 8'd0;
                        // A timer expiry coinciding with a voluntary release is not a timeout.
                        timeout     <= rel_to && !rel_done && !rel_req;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                    hold_cnt    <= 8'd0;
                end
            endcase
        end
    end

    decoder_2_to_4 u_grant_dec (
        .sel  (grant_idx),
        .ena  (grant_valid),
        .dout (grant)
    );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - self-checking bench for rr_grant_arbiter
// Two instances (MAX_HOLD=15 and MAX_HOLD=4) share stimulus; each has its own reference model.

module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;

    logic [3:0] g15, g4;
    logic [1:0] i15, i4;
    logic       v15, v4;
    logic       t15, t4;

    int n_chk;
    int n_err;

    rr_grant_arbiter #(.MAX_HOLD(15)) u15 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(g15), .grant_idx(i15), .grant_valid(v15), .timeout(t15)
    );

    rr_grant_arbiter #(.MAX_HOLD(4)) u4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(g4), .grant_idx(i4), .grant_valid(v4), .timeout(t4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [3:0] rq, logic [3:0] dn,
                                logic [3:0] g, logic [1:0] ix, logic v, logic t);
        vec_t x;
        x.do_rst = r; x.req = rq; x.done = dn;
        x.grant = g; x.idx = ix; x.valid = v; x.to = t;
        return x;
    endfunction

    // Reference model: owner is -1 when idle; priority search is plain modulo arithmetic.
    int m_owner [2];
    int m_last  [2];
    int m_ptr   [2];
    int m_hold  [2];
    bit m_to    [2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1; m_last[u] = 0; m_ptr[u] = 0; m_hold[u] = 0; m_to[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input int mh, input logic [3:0] r, input logic [3:0] d);
        int  o;
        bit  by_done, by_req, by_to, found;
        if (m_owner[u] < 0) begin
            m_to[u] = 0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr[u] + k) % 4]) begin
                    found      = 1;
                    o          = (m_ptr[u] + k) % 4;
                    m_owner[u] = o;
                    m_last[u]  = o;
                    m_hold[u]  = 1;
                    m_ptr[u]   = (o + 1) % 4;
                end
            end
        end else begin
            o       = m_owner[u];
            by_done = d[o];
            by_req  = !r[o];
            by_to   = (mh != 0) && (m_hold[u] == mh);
            if (by_done || by_req || by_to) begin
                m_owner[u] = -1;
                m_hold[u]  = 0;
                m_to[u]    = by_to && !by_done && !by_req;
            end else begin
                m_hold[u] = (m_hold[u] < 255) ? m_hold[u] + 1 : 255;
                m_to[u]   = 0;
            end
        end
    endtask

    function automatic logic [3:0] m_grant(int u);
        return (m_owner[u] < 0) ? 4'b0000 : 4'(1 << m_owner[u]);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] ix,
                             input logic v, input logic t,
                             input logic [3:0] eg, input logic [1:0] eix,
                             input logic ev, input logic et);
        check({tag, ".grant"}, 8'(g), 8'(eg));
        check({tag, ".grant_idx"}, 8'(ix), 8'(eix));
        check({tag, ".grant_valid"}, 8'(v), 8'(ev));
        check({tag, ".timeout"}, 8'(t), 8'(et));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] r_now;
    logic [3:0] d_now;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 4'b0000;

        do_reset();
        check_out("reset15", g15, i15, v15, t15, 4'b0000, 2'd0, 1'b0, 1'b0);
        check_out("reset4", g4, i4, v4, t4, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request, done release, MAX_HOLD=15 instance
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0));
        // All requesting, each owner releases in its 2nd grant cycle; pointer wraps 3->0
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0));
        // Non-owner done ignored, then release by request drop, done in idle ignored
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, 0));
        // Owner drops request mid-grant; next search starts at 1
        tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 0));

        foreach (tbl[n]) begin
            if (tbl[n].do_rst) do_reset();
            req  = tbl[n].req;
            done = tbl[n].done;
            step();
            check_out($sformatf("tbl[%0d]", n), g15, i15, v15, t15,
                      tbl[n].grant, tbl[n].idx, tbl[n].valid, tbl[n].to);
        end

        // Hold timeout, MAX_HOLD=4: exactly 4 grant cycles, one timeout pulse, then next requester
        do_reset();
        req = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            step();
            check_out($sformatf("hold.c%0d", c), g4, i4, v4, t4, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step();
        check_out("hold.expire", g4, i4, v4, t4, 4'b0000, 2'd1, 1'b0, 1'b1);
        step();
        check_out("hold.next", g4, i4, v4, t4, 4'b1000, 2'd3, 1'b1, 1'b0);

        // Owner's done coincides with hold limit: release without timeout
        do_reset();
        req = 4'b0010;
        step();
        check_out("coinc.g1", g4, i4, v4, t4, 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b0100;
        step();
        check_out("coinc.nonowner", g4, i4, v4, t4, 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b0000;
        step();
        step();
        check_out("coinc.g4", g4, i4, v4, t4, 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 4'b0010;
        step();
        check_out("coinc.release", g4, i4, v4, t4, 4'b0000, 2'd1, 1'b0, 1'b0);
        done = 4'b0000;
        step();
        check("coinc.to_after", 8'(t4), 8'd0);

        // Asynchronous reset between edges drops the grant immediately
        do_reset();
        req = 4'b0100;
        step();
        check_out("arst.pre", g4, i4, v4, t4, 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("arst.now4", g4, i4, v4, t4, 4'b0000, 2'd0, 1'b0, 1'b0);
        check_out("arst.now15", g15, i15, v15, t15, 4'b0000, 2'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        req = 4'b1010;
        step();
        check_out("arst.ptr0", g4, i4, v4, t4, 4'b0010, 2'd1, 1'b1, 1'b0);

        // Randomized run against the reference models
        do_reset();
        model_reset();
        r_now = 4'b0000;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) r_now = 4'($urandom_range(0, 15));
            d_now = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            req  = r_now;
            done = d_now;
            model_step(0, 15, r_now, d_now);
            model_step(1, 4, r_now, d_now);
            step();
            check_out($sformatf("rnd15.c%0d", c), g15, i15, v15, t15,
                      m_grant(0), 2'(m_last[0]), m_owner[0] >= 0, m_to[0]);
            check_out($sformatf("rnd4.c%0d", c), g4, i4, v4, t4,
                      m_grant(1), 2'(m_last[1]), m_owner[1] >= 0, m_to[1]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
